alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/writeback controller on the operand side of MASTER_ALU. Accepts 32-bit instruction words over a valid/ready handshake.
//  Decodes Cond/OpCode/S/Rd/Rn/Rm/IV, reads the internal 16x32 register file and drives the ALU operand ports.
//  Captures Result/New_Flag, then commits Rd and the NZCV flag register when the condition passes.
//  One instruction in flight; sits between the instruction source and the ALU.
// PARAMETERS
//  ALU_LAT  1  cycles from driving the ALU ports to sampling alu_result/alu_new_flag (1..15)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   synchronous, active-high
//  in_valid      in   1   instruction word valid
//  in_ready      out  1   controller idle; accepts on in_valid&in_ready
//  instr         in   32  [31:28]Cond [27:24]OpCode [23]S [22:19]Rd [18:15]Rn [14:11]Rm [10:0]imm
//  host_we       in   1   host register-file write, honoured in IDLE only
//  host_addr     in   4   host write address
//  host_wdata    in   32  host write data
//  dbg_addr      in   4   debug read address
//  dbg_rdata     out  32  R[dbg_addr], combinational
//  alu_reg1      out  32  R[Rn]
//  alu_reg2      out  32  R[Rm]
//  alu_iv        out  16  {5'b0, imm}
//  alu_opcode    out  4   OpCode
//  alu_cond      out  4   Cond
//  alu_s         out  1   S
//  alu_flag      out  4   current flag register {N,Z,C,V}
//  alu_result    in   32  ALU result
//  alu_new_flag  in   4   ALU flags {N,Z,C,V}
//  done          out  1   1-cycle pulse: instruction retired
//  skipped       out  1   valid with done: condition failed, nothing committed
//  illegal       out  1   valid with done: OpCode 1100..1111, nothing committed
//  flags         out  4   architectural flag register {N,Z,C,V}
// BEHAVIOUR
//  Reset: state IDLE, R0..R15=0, flags=0, all ALU outputs=0, done/skipped/illegal=0, in_ready=1.
//  Reset mid-instruction aborts it: no commit, no done.
//  FSM:
//   IDLE->READ on accept; instr is latched.
//   READ: register ALU ports from latched fields and the regfile. Go to EXEC.
//   EXEC: count ALU_LAT cycles, then sample alu_result/alu_new_flag. Go to WB.
//   WB: pulse done and commit. Go to IDLE.
//  Latency: accept at cycle 0, done at cycle 2+ALU_LAT, in_ready high at cycle 3+ALU_LAT.
//  ALU ports hold stable from READ through WB; operand values are sampled once in READ.
//  Cond (N,Z,C,V = flags[3:0]):
//   0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
//   8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
//  Cond is evaluated in WB against the flag register.
//  Commit in WB, only when cond passes and OpCode is legal:
//   - R[Rd] <= alu_result, for all legal opcodes except 1011 (CMP).
//   - flags <= alu_new_flag if S=1. CMP always updates flags regardless of S.
//  Rd==Rn/Rm: reads already sampled in READ, so the write in WB is safe.
//  Cond fails: done=1, skipped=1, no writes. Illegal opcode: done=1, illegal=1, no writes. Illegal takes priority over skipped.
//  host_we in IDLE writes at the clock edge. An instruction accepted on the same edge reads the new value in READ. host_we outside IDLE is dropped.
//  in_valid while busy: ignored; in_ready=0, no buffering.
// STRUCTURE
//  alu_pkg: opcode constants (ADD..CMP, 1011=CMP), cond codes, flag bit indices (N=3,Z=2,C=1,V=0), instr field offsets.
//  Sub-module: alu_cond_eval (cond[3:0], flags[3:0] -> pass), combinational, reused by branch logic.
//  Register file inline: 16x32 array, 2 sync-sampled read ports plus 1 debug read port.
// TESTING
//  1. host writes R1=5, R2=7; ADD AL S=1 Rd=3 Rn=1 Rm=2 -> done at cycle 3 (ALU_LAT=1), R3=12, flags=0000.
//  2. flags Z=0; EQ ADD Rd=4 -> done, skipped=1, R4 unchanged, flags unchanged.
//  3. CMP AL S=0, R1=R2=9 -> flags Z=1, no Rd write. Then EQ MOV Rd=5 commits.
//  4. OpCode 1101, Rd=6 -> done, illegal=1, R6 unchanged. in_valid held throughout: second accept only after in_ready.
//  5. reset asserted during EXEC -> no done, all regs/flags 0, in_ready=1 next cycle.
//  6. ALU_LAT=3: done at cycle 5. host_we during EXEC dropped; same-edge host_we+accept reads the new value.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU issue controller
package alu_pkg;

  // Instruction word field positions
  localparam int COND_LSB = 28;
  localparam int OP_LSB   = 24;
  localparam int S_BIT    = 23;
  localparam int RD_LSB   = 19;
  localparam int RN_LSB   = 15;
  localparam int RM_LSB   = 11;
  localparam int IMM_W    = 11;

  // Flag register bit indices {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_RSB = 4'h2, OP_ADC = 4'h3,
    OP_SBC = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_EOR = 4'h7,
    OP_BIC = 4'h8, OP_MOV = 4'h9, OP_MVN = 4'hA, OP_CMP = 4'hB
  } opcode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Opcodes above CMP are reserved and never commit
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// rtl/alu_cond_eval.sv - condition code evaluation against NZCV flags
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the 16 condition codes into a single pass bit
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue operand/writeback controller for MASTER_ALU
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        host_we,
  input  logic [3:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_rdata,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [15:0] alu_iv,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [3:0]  alu_flag,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_new_flag,
  output logic        done,
  output logic        skipped,
  output logic        illegal,
  output logic [3:0]  flags
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_e      state_q;
  logic [31:0] instr_q;
  logic [3:0]  cnt_q;
  logic [31:0] result_q;
  logic [3:0]  new_flag_q;
  logic [3:0]  flags_q;
  logic [31:0] regs_q [16];
  logic [31:0] alu_reg1_q, alu_reg2_q;
  logic [15:0] alu_iv_q;
  logic [3:0]  alu_opcode_q, alu_cond_q;
  logic        alu_s_q;
  logic        done_q, skipped_q, illegal_q;

  logic [3:0]       cond_w, op_w, rd_w, rn_w, rm_w;
  logic             s_w;
  logic [IMM_W-1:0] imm_w;
  logic             legal_w;
  logic             cond_pass;

  // Field decode of the latched instruction word
  assign cond_w  = instr_q[COND_LSB +: 4];
  assign op_w    = instr_q[OP_LSB +: 4];
  assign s_w     = instr_q[S_BIT];
  assign rd_w    = instr_q[RD_LSB +: 4];
  assign rn_w    = instr_q[RN_LSB +: 4];
  assign rm_w    = instr_q[RM_LSB +: 4];
  assign imm_w   = instr_q[IMM_W-1:0];
  assign legal_w = op_legal(op_w);

  // Flags only change at the end of WB, so this value is stable from EXEC through WB
  alu_cond_eval u_cond_eval (
    .cond_i  (cond_w),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign dbg_rdata  = regs_q[dbg_addr];
  assign alu_reg1   = alu_reg1_q;
  assign alu_reg2   = alu_reg2_q;
  assign alu_iv     = alu_iv_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_cond   = alu_cond_q;
  assign alu_s      = alu_s_q;
  assign alu_flag   = flags_q;
  assign flags      = flags_q;
  assign done       = done_q;
  assign skipped    = skipped_q;
  assign illegal    = illegal_q;

  // Issue FSM: accept, read operands, wait out ALU latency, retire and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      new_flag_q   <= '0;
      flags_q      <= '0;
      alu_reg1_q   <= '0;
      alu_reg2_q   <= '0;
      alu_iv_q     <= '0;
      alu_opcode_q <= '0;
      alu_cond_q   <= '0;
      alu_s_q      <= 1'b0;
      done_q       <= 1'b0;
      skipped_q    <= 1'b0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Host writes land on this edge, so a same-edge accept sees them in READ
          if (host_we) begin
            regs_q[host_addr] <= host_wdata;
          end
          if (in_valid) begin
            instr_q <= instr;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          alu_reg1_q   <= regs_q[rn_w];
          alu_reg2_q   <= regs_q[rm_w];
          alu_iv_q     <= {5'b0, imm_w};
          alu_opcode_q <= op_w;
          alu_cond_q   <= cond_w;
          alu_s_q      <= s_w;
          cnt_q        <= '0;
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cnt_q == LAT_LAST) begin
            result_q   <= alu_result;
            new_flag_q <= alu_new_flag;
            done_q     <= 1'b1;
            illegal_q  <= !legal_w;
            skipped_q  <= legal_w && !cond_pass;
            state_q    <= ST_WB;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_WB: begin
          if (legal_w && cond_pass) begin
            if (op_w != OP_CMP) begin
              regs_q[rd_w] <= result_q;
            end
            if (s_w || (op_w == OP_CMP)) begin
              flags_q <= new_flag_q;
            end
          end
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl at ALU_LAT 1 and 3
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        [2];
  logic        in_valid     [2];
  logic        in_ready     [2];
  logic [31:0] instr        [2];
  logic        host_we      [2];
  logic [3:0]  host_addr    [2];
  logic [31:0] host_wdata   [2];
  logic [3:0]  dbg_addr     [2] = '{4'd0, 4'd0};
  logic [31:0] dbg_rdata    [2];
  logic [31:0] alu_reg1     [2];
  logic [31:0] alu_reg2     [2];
  logic [15:0] alu_iv       [2];
  logic [3:0]  alu_opcode   [2];
  logic [3:0]  alu_cond     [2];
  logic        alu_s        [2];
  logic [3:0]  alu_flag     [2];
  logic [31:0] alu_result   [2];
  logic [3:0]  alu_new_flag [2];
  logic        done         [2];
  logic        skipped      [2];
  logic        illegal      [2];
  logic [3:0]  flags        [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_issue_ctrl #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .instr        (instr[g]),
      .host_we      (host_we[g]),
      .host_addr    (host_addr[g]),
      .host_wdata   (host_wdata[g]),
      .dbg_addr     (dbg_addr[g]),
      .dbg_rdata    (dbg_rdata[g]),
      .alu_reg1     (alu_reg1[g]),
      .alu_reg2     (alu_reg2[g]),
      .alu_iv       (alu_iv[g]),
      .alu_opcode   (alu_opcode[g]),
      .alu_cond     (alu_cond[g]),
      .alu_s        (alu_s[g]),
      .alu_flag     (alu_flag[g]),
      .alu_result   (alu_result[g]),
      .alu_new_flag (alu_new_flag[g]),
      .done         (done[g]),
      .skipped      (skipped[g]),
      .illegal      (illegal[g]),
      .flags        (flags[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Architectural model: register file and flags per DUT
  logic [31:0] mreg   [2][16];
  logic [3:0]  mflags [2];
  int          lat    [2] = '{1, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                     input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                     input logic [10:0] imm);
    return {c, op, s, rd, rn, rm, imm};
  endfunction

  // Idle-time comparison of flags and a rotating debug-read register against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset[d] === 1'b0 && in_ready[d] === 1'b1) begin
        chk("flags", 32'(flags[d]), 32'(mflags[d]));
        chk("alu_flag", 32'(alu_flag[d]), 32'(mflags[d]));
        chk("dbg_rdata", dbg_rdata[d], mreg[d][dbg_addr[d]]);
        dbg_addr[d] = dbg_addr[d] + 4'd1;
      end
    end
  end

  // All tasks start and end on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input int d, input logic [3:0] a, input logic [31:0] v);
    host_we[d] = 1'b1; host_addr[d] = a; host_wdata[d] = v;
    @(posedge clk); #1;
    host_we[d] = 1'b0;
    mreg[d][a] = v;
    @(negedge clk);
  endtask

  task automatic issue(input int d, input logic [31:0] ins, input logic [31:0] res,
                       input logic [3:0] nf, input bit hold, input logic [31:0] next_ins,
                       input bit hw, input logic [3:0] hwa, input logic [31:0] hwd,
                       input bit drop);
    logic [3:0]  c, op, rd, rn, rm, f0;
    logic        s;
    logic [10:0] imm;
    logic [31:0] r1, r2;
    bit          ill, skp;
    int          l;
    c = ins[31:28]; op = ins[27:24]; s = ins[23]; rd = ins[22:19];
    rn = ins[18:15]; rm = ins[14:11]; imm = ins[10:0];
    l = lat[d];
    chk("ready_before_accept", 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    instr[d] = ins;
    if (hw) begin
      host_we[d] = 1'b1; host_addr[d] = hwa; host_wdata[d] = hwd;
    end
    @(posedge clk); #1;
    if (hw) begin
      host_we[d] = 1'b0;
      mreg[d][hwa] = hwd;
    end
    if (hold) instr[d] = next_ins;
    else      in_valid[d] = 1'b0;
    r1 = mreg[d][rn]; r2 = mreg[d][rm]; f0 = mflags[d];
    ill = (op >= 4'hC);
    skp = !ill && !cond_ok(c, f0);
    for (int cy = 1; cy <= 2 + l; cy++) begin
      alu_result[d]   = (cy == 1 + l) ? res : (32'hBAD0_0000 | 32'(cy));
      alu_new_flag[d] = (cy == 1 + l) ? nf : ~nf;
      host_we[d] = drop && (cy == 2);
      if (drop && cy == 2) begin
        host_addr[d] = rn; host_wdata[d] = 32'h77;
      end
      @(negedge clk);
      chk("done_timing", 32'(done[d]), 32'(cy == 2 + l));
      chk("in_ready_busy", 32'(in_ready[d]), 32'd0);
      if (cy >= 2) begin
        chk("alu_reg1", alu_reg1[d], r1);
        chk("alu_reg2", alu_reg2[d], r2);
        chk("alu_iv", 32'(alu_iv[d]), 32'({5'b0, imm}));
        chk("alu_opcode", 32'(alu_opcode[d]), 32'(op));
        chk("alu_cond", 32'(alu_cond[d]), 32'(c));
        chk("alu_s", 32'(alu_s[d]), 32'(s));
        chk("alu_flag_busy", 32'(alu_flag[d]), 32'(f0));
      end
      if (cy == 2 + l) begin
        chk("skipped", 32'(skipped[d]), 32'(skp));
        chk("illegal", 32'(illegal[d]), 32'(ill));
      end
      @(posedge clk); #1;
    end
    host_we[d] = 1'b0;
    if (!ill && !skp) begin
      if (op != 4'hB) mreg[d][rd] = res;
      if (s || op == 4'hB) mflags[d] = nf;
    end
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready[d]), 32'd1);
    chk("done_clear", 32'(done[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; in_valid[d] = 1'b0; instr[d] = '0;
      host_we[d] = 1'b0; host_addr[d] = '0; host_wdata[d] = '0;
      alu_result[d] = '0; alu_new_flag[d] = '0;
      mflags[d] = '0;
      for (int i = 0; i < 16; i++) mreg[d][i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clk);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
      chk("rst_done", 32'(done[d]), 32'd0);
      chk("rst_skipped", 32'(skipped[d]), 32'd0);
      chk("rst_illegal", 32'(illegal[d]), 32'd0);
      chk("rst_flags", 32'(flags[d]), 32'd0);
      chk("rst_alu_reg1", alu_reg1[d], 32'd0);
      chk("rst_alu_iv", 32'(alu_iv[d]), 32'd0);
      chk("rst_alu_opcode", 32'(alu_opcode[d]), 32'd0);
    end
    idle(16);

    // 1: ADD AL S=1 R3 = R1 + R2
    host_write(0, 4'd1, 32'd5);
    host_write(0, 4'd2, 32'd7);
    issue(0, mk(4'hE, 4'h0, 1'b1, 4'd3, 4'd1, 4'd2, 11'h5A5), 32'd12, 4'b0000,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_r3", mreg[0][3], 32'd12);
    chk("lit_flags_t1", 32'(flags[0]), 32'd0);

    // 2: EQ with Z=0 is skipped
    issue(0, mk(4'h0, 4'h0, 1'b1, 4'd4, 4'd1, 4'd2, 11'h001), 32'd99, 4'b0100,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_r4", mreg[0][4], 32'd0);

    // 3: CMP with S=0 sets flags, then EQ MOV commits
    host_write(0, 4'd1, 32'd9);
    host_write(0, 4'd2, 32'd9);
    issue(0, mk(4'hE, 4'hB, 1'b0, 4'd7, 4'd1, 4'd2, 11'h000), 32'd0, 4'b0110,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_flags_cmp", 32'(flags[0]), 32'h6);
    issue(0, mk(4'h0, 4'h9, 1'b0, 4'd5, 4'd0, 4'd2, 11'h02A), 32'd42, 4'b1000,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_r5", mreg[0][5], 32'd42);
    chk("lit_r7", mreg[0][7], 32'd0);
    chk("lit_flags_mov", 32'(mflags[0]), 32'h6);

    // 4: illegal opcodes with in_valid held; illegal wins over a failing NV
    issue(0, mk(4'hE, 4'hD, 1'b1, 4'd6, 4'd1, 4'd2, 11'h003), 32'd11, 4'b1111,
          1'b1, mk(4'hF, 4'hE, 1'b1, 4'd6, 4'd2, 4'd1, 11'h004), 1'b0, '0, '0, 1'b0);
    issue(0, mk(4'hF, 4'hE, 1'b1, 4'd6, 4'd2, 4'd1, 11'h004), 32'd22, 4'b1111,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    issue(0, mk(4'hF, 4'h0, 1'b1, 4'd6, 4'd1, 4'd1, 11'h005), 32'd33, 4'b1111,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_r6", mreg[0][6], 32'd0);

    // Rd equal to Rn: operand read before the write
    issue(0, mk(4'hE, 4'h0, 1'b0, 4'd1, 4'd1, 4'd2, 11'h7FF), 32'd18, 4'b0001,
          1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("lit_r1", mreg[0][1], 32'd18);
    idle(16);

    // 5: reset during EXEC aborts the instruction
    in_valid[0] = 1'b1;
    instr[0] = mk(4'hE, 4'h0, 1'b1, 4'd11, 4'd1, 4'd2, 11'h010);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    alu_result[0] = 32'h1234; alu_new_flag[0] = 4'b1010;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    mflags[0] = '0;
    for (int i = 0; i < 16; i++) mreg[0][i] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_done", 32'(done[0]), 32'd0);
      chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
      chk("abort_alu_reg1", alu_reg1[0], 32'd0);
      chk("abort_alu_opcode", 32'(alu_opcode[0]), 32'd0);
    end
    idle(16);

    // 6: ALU_LAT=3, same-edge host write is read, write during EXEC dropped
    issue(1, mk(4'hE, 4'h0, 1'b1, 4'd9, 4'd8, 4'd0, 11'h123), 32'd100, 4'b0010,
          1'b0, '0, 1'b1, 4'd8, 32'd100, 1'b1);
    chk("lit_r9", mreg[1][9], 32'd100);
    chk("lit_r8", mreg[1][8], 32'd100);
    chk("lit_flags_t6", 32'(flags[1]), 32'h2);
    idle(17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
